wfg_stim_mem_core: RTL

Memory-playback engine of the stimulus-memory channel: sits directly downstream of the stim_mem Wishbone register block and consumes its CTRL.EN, START.VAL, END.VAL and INC.VAL outputs. While enabled it walks an address pointer from START to END in steps of INC, wrapping back to START. For each address it reads one word from an external single-port SRAM and presents the word as a sample on the wfg AXI-stream output toward the drive/output stages.

---
 rtl/wfg_stim_mem_core.sv | 82 ++++++++
 1 files changed

// File: rtl/wfg_stim_mem_core.sv
// Stimulus-memory playback engine: walks START..END by INC, reads SRAM,
// and presents each word as one AXI-stream sample.
module wfg_stim_mem_core #(
  parameter int ADDRW = 16,
  parameter int DATAW = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             ctrl_en_q_i,
  input  logic [15:0]      start_val_q_i,
  input  logic [15:0]      end_val_q_i,
  input  logic [7:0]       inc_val_q_i,
  output logic             mem_csb_o,
  output logic [ADDRW-1:0] mem_addr_o,
  input  logic [DATAW-1:0] mem_dout_i,
  input  logic             wfg_axis_tready_i,
  output logic             wfg_axis_tvalid_o,
  output logic [DATAW-1:0] wfg_axis_tdata_o
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LATCH,
    VALID
  } state_t;

  state_t           r_state;
  logic [15:0]      r_ptr;
  logic             r_tvalid;
  logic [DATAW-1:0] r_tdata;

  logic [16:0]      w_sum;
  logic             w_wrap;
  logic [15:0]      w_next_ptr;

  // 17-bit sum so a step past 0xFFFF reloads START instead of wrapping
  assign w_sum      = {1'b0, r_ptr} + {9'd0, inc_val_q_i};
  assign w_wrap     = (r_ptr >= end_val_q_i) ||
                      (w_sum > {1'b0, end_val_q_i});
  assign w_next_ptr = w_wrap ? start_val_q_i : w_sum[15:0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (ctrl_en_q_i) begin
            r_ptr   <= start_val_q_i;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          r_state <= LATCH;
        end
        LATCH: begin
          r_tdata  <= mem_dout_i;
          r_tvalid <= 1'b1;
          r_ptr    <= w_next_ptr;
          r_state  <= VALID;
        end
        VALID: begin
          if (wfg_axis_tready_i) begin
            r_tvalid <= 1'b0;
            r_state  <= ctrl_en_q_i ? FETCH : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_csb_o         = (r_state != FETCH);
  assign mem_addr_o        = ADDRW'(r_ptr);
  assign wfg_axis_tvalid_o = r_tvalid;
  assign wfg_axis_tdata_o  = r_tdata;

endmodule
